// File: rtl/riscv_trace_capture_if.sv
// Core tracer/data-bus inputs and trace-record output bundle for riscv_trace_capture.
// Optional macro RV_TRACE_TIMESTAMP_EN adds the out_timestamp field.
interface riscv_trace_capture_if;
   logic        valid;
   logic [31:0] instr;
   logic        trap;
   logic [4:0]  rd_addr;
   logic [31:0] rd_wdata;
   logic [31:0] pc;
   logic        dvalid;
   logic        dready;
   logic        dwrite;
   logic [31:0] daddr;
   logic [3:0]  dwstb;
   logic [31:0] dwdata;
   logic [31:0] drdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_rd_wdata;
   logic [31:0] out_mem_addr;
   logic [31:0] out_mem_data;
   logic        out_intr;
   logic [4:0]  out_rd_addr;
   logic [3:0]  out_mem_rmask;
   logic [3:0]  out_mem_wmask;
`ifdef RV_TRACE_TIMESTAMP_EN
   logic [31:0] out_timestamp;
`endif

   modport master (
      output valid, instr, trap, rd_addr, rd_wdata, pc,
      output dvalid, dready, dwrite, daddr, dwstb, dwdata, drdata, out_ready,
      input  out_valid, out_pc, out_instr, out_rd_wdata, out_mem_addr, out_mem_data,
      input  out_intr, out_rd_addr, out_mem_rmask, out_mem_wmask
`ifdef RV_TRACE_TIMESTAMP_EN
      , input out_timestamp
`endif
   );

   modport slave (
      input  valid, instr, trap, rd_addr, rd_wdata, pc,
      input  dvalid, dready, dwrite, daddr, dwstb, dwdata, drdata, out_ready,
      output out_valid, out_pc, out_instr, out_rd_wdata, out_mem_addr, out_mem_data,
      output out_intr, out_rd_addr, out_mem_rmask, out_mem_wmask
`ifdef RV_TRACE_TIMESTAMP_EN
      , output out_timestamp
`endif
   );
endinterface

// File: rtl/riscv_trace_capture.sv
// Retirement-trace front end: merges data accesses into retire records, buffers them in a FWFT FIFO.
// Optional macro RV_TRACE_TIMESTAMP_EN adds a 32-bit push-cycle timestamp to every record.
module riscv_trace_capture #(
   parameter int FIFO_DEPTH     = 8,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   riscv_trace_capture_if.slave      tr,
   input  logic                      ovf_clr,
   output logic                      overflow,
   output logic [DROP_CNT_WIDTH-1:0] drop_count
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
   } acc_t;

   typedef struct packed {
`ifdef RV_TRACE_TIMESTAMP_EN
      logic [31:0] timestamp;
`endif
      logic [31:0] pc;
      logic [31:0] instr;
      logic        intr;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      acc_t        mem;
   } rec_t;

   logic                      acc, push, pop, push_ok, drop, full, empty;
   acc_t                      acc_cur, cap_q, cap_d;
   rec_t                      rec_in, head, last_q, last_d, out_rec;
   rec_t                      mem_q [FIFO_DEPTH];
   logic [AW:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                      overflow_q, overflow_d;
   logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
`ifdef RV_TRACE_TIMESTAMP_EN
   logic [31:0]               ts_q;
`endif

   always_comb begin
      acc           = tr.dvalid && tr.dready;
      push          = tr.valid || tr.trap;
      acc_cur.addr  = tr.daddr;
      acc_cur.data  = tr.dwrite ? tr.dwdata : tr.drdata;
      acc_cur.rmask = tr.dwrite ? 4'h0 : 4'hF;
      acc_cur.wmask = tr.dwrite ? tr.dwstb : 4'h0;
   end

   // A same-cycle access bypasses the capture register; every push empties it.
   always_comb begin
      rec_in.pc       = tr.pc;
      rec_in.instr    = tr.instr;
      rec_in.intr     = tr.trap;
      rec_in.rd_addr  = tr.rd_addr;
      rec_in.rd_wdata = tr.rd_wdata;
      rec_in.mem      = acc ? acc_cur : cap_q;
`ifdef RV_TRACE_TIMESTAMP_EN
      rec_in.timestamp = ts_q;
`endif
      cap_d = cap_q;
      if (push)     cap_d = '0;
      else if (acc) cap_d = acc_cur;
   end

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      head     = mem_q[rd_ptr_q[AW-1:0]];
      pop      = !empty && tr.out_ready;
      push_ok  = push && (!full || pop);
      drop     = push && full && !pop;
      wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
      last_d   = pop ? head : last_q;
      out_rec  = empty ? last_q : head;
   end

   // A drop in the same cycle as a clear leaves exactly one drop recorded.
   always_comb begin
      overflow_d = overflow_q;
      drop_d     = drop_q;
      if (ovf_clr) begin
         overflow_d = 1'b0;
         drop_d     = '0;
      end
      if (drop) begin
         overflow_d = 1'b1;
         if (ovf_clr)     drop_d = DROP_CNT_WIDTH'(1);
         else if (~&drop_q) drop_d = drop_q + DROP_CNT_WIDTH'(1);
      end
   end

   // NOTE: record storage has no reset; validity comes solely from the pointers.
   always_ff @(posedge clock) begin
      if (!reset && push_ok) mem_q[wr_ptr_q[AW-1:0]] <= rec_in;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cap_q      <= '0;
         last_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         cap_q      <= cap_d;
         last_q     <= last_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

`ifdef RV_TRACE_TIMESTAMP_EN
   always_ff @(posedge clock) begin
      if (reset) ts_q <= '0;
      else       ts_q <= ts_q + 32'd1;
   end
   assign tr.out_timestamp = out_rec.timestamp;
`endif

   assign tr.out_valid     = !empty;
   assign tr.out_pc        = out_rec.pc;
   assign tr.out_instr     = out_rec.instr;
   assign tr.out_intr      = out_rec.intr;
   assign tr.out_rd_addr   = out_rec.rd_addr;
   assign tr.out_rd_wdata  = out_rec.rd_wdata;
   assign tr.out_mem_addr  = out_rec.mem.addr;
   assign tr.out_mem_data  = out_rec.mem.data;
   assign tr.out_mem_rmask = out_rec.mem.rmask;
   assign tr.out_mem_wmask = out_rec.mem.wmask;
   assign overflow         = overflow_q;
   assign drop_count       = drop_q;
endmodule

// File: tb/tb_riscv_trace_capture.sv
// Self-checking bench for riscv_trace_capture: directed scenarios plus randomized traffic
// checked against a queue-based record model. Honours RV_TRACE_TIMESTAMP_EN.
module tb_riscv_trace_capture;
   localparam int DEPTH = 8;
   localparam int DW    = 16;

   typedef struct packed {
`ifdef RV_TRACE_TIMESTAMP_EN
      logic [31:0] ts;
`endif
      logic [31:0] pc;
      logic [31:0] instr;
      logic        intr;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] mem_addr;
      logic [31:0] mem_data;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
   } trec_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          ovf_clr = 1'b0;
   logic          overflow;
   logic [DW-1:0] drop_count;
   int            checks = 0;
   int            failures = 0;

   // Reference model state
   trec_t         mq[$];
   trec_t         m_last;
   logic [31:0]   m_cap_addr, m_cap_data;
   logic [3:0]    m_cap_rmask, m_cap_wmask;
   bit            m_ovf;
   int            m_drop;
   logic [31:0]   m_ts;

   riscv_trace_capture_if tif ();

   riscv_trace_capture #(.FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(DW)) dut (
      .clock      (clock),
      .reset      (reset),
      .tr         (tif),
      .ovf_clr    (ovf_clr),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clock = ~clock;

   function automatic trec_t act_rec();
      trec_t r;
`ifdef RV_TRACE_TIMESTAMP_EN
      r.ts = tif.out_timestamp;
`endif
      r.pc = tif.out_pc;             r.instr = tif.out_instr;
      r.intr = tif.out_intr;         r.rd_addr = tif.out_rd_addr;
      r.rd_wdata = tif.out_rd_wdata; r.mem_addr = tif.out_mem_addr;
      r.mem_data = tif.out_mem_data; r.rmask = tif.out_mem_rmask;
      r.wmask = tif.out_mem_wmask;
      return r;
   endfunction

   function automatic trec_t exp_rec();
      return (mq.size() > 0) ? mq[0] : m_last;
   endfunction

   task automatic idle();
      tif.valid = 0; tif.trap = 0; tif.instr = 0; tif.rd_addr = 0; tif.rd_wdata = 0; tif.pc = 0;
      tif.dvalid = 0; tif.dready = 0; tif.dwrite = 0; tif.daddr = 0; tif.dwstb = 0;
      tif.dwdata = 0; tif.drdata = 0;
      ovf_clr = 0;
   endtask

   task automatic retire(input logic [31:0] pc);
      tif.valid = 1; tif.pc = pc; tif.instr = 32'h0000_0013; tif.rd_addr = 0; tif.rd_wdata = 0;
   endtask

   // Advance the model by the rules of the trace front end, then clock the DUT.
   task automatic step();
      bit    pop, acc, dropped;
      trec_t r;
      logic [31:0] a_data;
      logic [3:0]  a_rm, a_wm;
      if (reset) begin
         mq.delete(); m_last = '0; m_ovf = 0; m_drop = 0; m_ts = 0;
         m_cap_addr = 0; m_cap_data = 0; m_cap_rmask = 0; m_cap_wmask = 0;
      end else begin
         pop = (mq.size() > 0) && tif.out_ready;
         acc = tif.dvalid && tif.dready;
         dropped = 0;
         a_data = tif.dwrite ? tif.dwdata : tif.drdata;
         a_rm   = tif.dwrite ? 4'h0 : 4'hF;
         a_wm   = tif.dwrite ? tif.dwstb : 4'h0;
         if (pop) m_last = mq.pop_front();
         if (tif.valid || tif.trap) begin
`ifdef RV_TRACE_TIMESTAMP_EN
            r.ts = m_ts;
`endif
            r.pc = tif.pc; r.instr = tif.instr; r.intr = tif.trap;
            r.rd_addr = tif.rd_addr; r.rd_wdata = tif.rd_wdata;
            r.mem_addr = acc ? tif.daddr : m_cap_addr;
            r.mem_data = acc ? a_data : m_cap_data;
            r.rmask    = acc ? a_rm : m_cap_rmask;
            r.wmask    = acc ? a_wm : m_cap_wmask;
            m_cap_addr = 0; m_cap_data = 0; m_cap_rmask = 0; m_cap_wmask = 0;
            if (mq.size() < DEPTH) mq.push_back(r);
            else dropped = 1;
         end else if (acc) begin
            m_cap_addr = tif.daddr; m_cap_data = a_data; m_cap_rmask = a_rm; m_cap_wmask = a_wm;
         end
         if (ovf_clr) begin m_ovf = 0; m_drop = 0; end
         if (dropped) begin
            m_ovf = 1;
            if (m_drop < (1 << DW) - 1) m_drop++;
         end
         m_ts++;
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      idle(); tif.out_ready = 0; reset = 1;
      step(); step();
      reset = 0;
      checks++; if (tif.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid act=%0b exp=0", tif.out_valid); end
      checks++; if (act_rec() !== trec_t'(0)) begin failures++; $display("FAIL reset_fields act=%h exp=0", act_rec()); end
      checks++; if (overflow !== 1'b0 || drop_count !== '0) begin failures++; $display("FAIL reset_ovf act=%0b/%0d exp=0/0", overflow, drop_count); end
   endtask

   task automatic test_basic();
      retire(32'h100);
      step(); idle();
      checks++; if (tif.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid act=%0b exp=1", tif.out_valid); end
      checks++;
      if (tif.out_pc !== 32'h100 || tif.out_instr !== 32'h13 || tif.out_rd_addr !== 5'd0 ||
          tif.out_mem_rmask !== 4'h0 || tif.out_mem_wmask !== 4'h0) begin
         failures++; $display("FAIL basic_fields act=%h pc=100 instr=13 masks=0", act_rec());
      end
      tif.out_ready = 1; step(); tif.out_ready = 0;
      checks++; if (tif.out_valid !== 1'b0) begin failures++; $display("FAIL basic_pop act=%0b exp=0", tif.out_valid); end
      checks++; if (tif.out_pc !== 32'h100) begin failures++; $display("FAIL basic_hold act=%h exp=100", tif.out_pc); end
   endtask

   task automatic test_store();
      tif.dvalid = 1; tif.dready = 1; tif.dwrite = 1; tif.daddr = 32'h2000;
      tif.dwstb = 4'b0011; tif.dwdata = 32'hCAFE;
      step(); idle(); step();
      retire(32'h200); step();
      retire(32'h204); step(); idle();
      checks++;
      if (tif.out_mem_addr !== 32'h2000 || tif.out_mem_wmask !== 4'h3 || tif.out_mem_rmask !== 4'h0 ||
          tif.out_mem_data !== 32'hCAFE) begin
         failures++; $display("FAIL store_rec act=%h addr=2000 wmask=3 rmask=0 data=cafe", act_rec());
      end
      tif.out_ready = 1; step(); tif.out_ready = 0;
      checks++;
      if (tif.out_pc !== 32'h204 || tif.out_mem_addr !== 0 || tif.out_mem_data !== 0 ||
          tif.out_mem_rmask !== 0 || tif.out_mem_wmask !== 0) begin
         failures++; $display("FAIL store_next act=%h exp pc=204 mem=0", act_rec());
      end
      tif.out_ready = 1; step(); tif.out_ready = 0;
   endtask

   task automatic test_load_bypass();
      retire(32'h300);
      tif.dvalid = 1; tif.dready = 1; tif.dwrite = 0; tif.daddr = 32'h4000; tif.drdata = 32'h12345678;
      step(); idle();
      retire(32'h304); step(); idle();
      checks++;
      if (tif.out_mem_rmask !== 4'hF || tif.out_mem_data !== 32'h12345678 || tif.out_mem_addr !== 32'h4000 ||
          tif.out_mem_wmask !== 4'h0) begin
         failures++; $display("FAIL load_bypass act=%h rmask=f data=12345678", act_rec());
      end
      tif.out_ready = 1; step(); tif.out_ready = 0;
      checks++;
      if (tif.out_pc !== 32'h304 || tif.out_mem_rmask !== 0 || tif.out_mem_data !== 0) begin
         failures++; $display("FAIL load_next act=%h exp pc=304 mem=0", act_rec());
      end
      tif.out_ready = 1; step(); tif.out_ready = 0;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 10; i++) begin retire(32'h1000 + 4 * i); step(); end
      idle();
      checks++; if (overflow !== 1'b1 || drop_count !== 16'd2) begin failures++; $display("FAIL ovf_count act=%0b/%0d exp=1/2", overflow, drop_count); end
      tif.out_ready = 1;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (tif.out_valid !== 1'b1 || tif.out_pc !== 32'h1000 + 4 * i) begin
            failures++; $display("FAIL ovf_order[%0d] act=%0b/%h exp=1/%h", i, tif.out_valid, tif.out_pc, 32'h1000 + 4 * i);
         end
         step();
      end
      tif.out_ready = 0;
      checks++; if (tif.out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained act=%0b exp=0", tif.out_valid); end
      ovf_clr = 1; step(); ovf_clr = 0;
      checks++; if (overflow !== 1'b0 || drop_count !== '0) begin failures++; $display("FAIL ovf_clr act=%0b/%0d exp=0/0", overflow, drop_count); end
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < DEPTH; i++) begin retire(32'h3000 + 4 * i); step(); end
      idle();
      for (int i = 0; i < 3; i++) begin
         checks++; if (tif.out_pc !== 32'h3000 || tif.out_valid !== 1'b1) begin failures++; $display("FAIL full_stable act=%h exp=3000", tif.out_pc); end
         step();
      end
      tif.out_ready = 1; retire(32'h3020); step(); idle(); tif.out_ready = 0;
      checks++; if (overflow !== 1'b0 || drop_count !== '0) begin failures++; $display("FAIL full_pop_nodrop act=%0b/%0d exp=0/0", overflow, drop_count); end
      checks++; if (tif.out_pc !== 32'h3004) begin failures++; $display("FAIL full_pop_head act=%h exp=3004", tif.out_pc); end
      // Still full: two plain drops, then a drop together with a clear.
      retire(32'h3F00); step(); step();
      ovf_clr = 1; step(); idle();
      checks++; if (overflow !== 1'b1 || drop_count !== 16'd1) begin failures++; $display("FAIL drop_clr_same act=%0b/%0d exp=1/1", overflow, drop_count); end
      tif.out_ready = 1;
      for (int i = 1; i <= DEPTH; i++) begin
         checks++; if (tif.out_pc !== 32'h3000 + 4 * i) begin failures++; $display("FAIL full_drain[%0d] act=%h exp=%h", i, tif.out_pc, 32'h3000 + 4 * i); end
         step();
      end
      ovf_clr = 1; step(); ovf_clr = 0; tif.out_ready = 0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         tif.valid = ($urandom_range(0, 99) < 45); tif.trap = ($urandom_range(0, 99) < 8);
         tif.pc = $urandom; tif.instr = $urandom; tif.rd_addr = 5'($urandom);
         tif.rd_wdata = $urandom; tif.dvalid = ($urandom_range(0, 99) < 40);
         tif.dready = ($urandom_range(0, 99) < 70); tif.dwrite = 1'($urandom);
         tif.daddr = $urandom; tif.dwstb = 4'($urandom); tif.dwdata = $urandom; tif.drdata = $urandom;
         tif.out_ready = ((c / 50) % 2 == 0) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 80);
         ovf_clr = ($urandom_range(0, 99) < 3);
         step();
         checks++; if (tif.out_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_valid[%0d] act=%0b exp=%0b", c, tif.out_valid, mq.size() > 0); end
         checks++; if (act_rec() !== exp_rec()) begin failures++; $display("FAIL rnd_rec[%0d] act=%h exp=%h", c, act_rec(), exp_rec()); end
         checks++;
         if (overflow !== m_ovf || drop_count !== DW'(m_drop)) begin
            failures++; $display("FAIL rnd_ovf[%0d] act=%0b/%0d exp=%0b/%0d", c, overflow, drop_count, m_ovf, m_drop);
         end
      end
      idle(); tif.out_ready = 1;
      for (int c = 0; c < DEPTH + 1; c++) step();
      ovf_clr = 1; step(); idle(); tif.out_ready = 0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin retire(32'h5000 + 4 * i); step(); end
      idle();
      tif.dvalid = 1; tif.dready = 1; tif.dwrite = 1; tif.daddr = 32'h6000; tif.dwstb = 4'hF; tif.dwdata = 32'hDEAD;
      step(); idle();
      reset = 1; step(); reset = 0;
      checks++; if (tif.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid act=%0b exp=0", tif.out_valid); end
      for (int i = 0; i < 5; i++) step();
      retire(32'h7000); step(); idle();
      checks++;
      if (tif.out_valid !== 1'b1 || tif.out_pc !== 32'h7000 || tif.out_mem_addr !== 0 || tif.out_mem_data !== 0 ||
          tif.out_mem_wmask !== 0 || tif.out_mem_rmask !== 0) begin
         failures++; $display("FAIL rst_mid_first act=%h exp pc=7000 mem=0", act_rec());
      end
`ifdef RV_TRACE_TIMESTAMP_EN
      checks++; if (tif.out_timestamp !== 32'd5) begin failures++; $display("FAIL rst_mid_ts act=%0d exp=5", tif.out_timestamp); end
`endif
      checks++; if (act_rec() !== exp_rec()) begin failures++; $display("FAIL rst_mid_model act=%h exp=%h", act_rec(), exp_rec()); end
      tif.out_ready = 1; step(); tif.out_ready = 0;
      checks++; if (tif.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_drain act=%0b exp=0", tif.out_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_store();
      test_load_bypass();
      test_overflow();
      test_full_pop();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/riscv_trace_capture.md
Name: riscv_trace_capture

Overview:
Synthesizable retirement-trace front end between the RISC-V core's tracer/data-bus signals and the riscv_debug_bfm (or any trace sink).
- Merges data-memory accesses into the record of the instruction that retires them.
- Buffers retirement records in a small FIFO, presented to the sink over a valid/ready handshake.
- Replaces ad-hoc bench-side capture logic. Same block serves simulation and on-chip trace.

Parameters:
FIFO_DEPTH, 8, record entries; power of 2, minimum 2
DROP_CNT_WIDTH, 16, width of saturating dropped-record counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
valid  in  1  instruction retired this cycle
instr  in  32  retired instruction word
trap  in  1  trap/interrupt taken this cycle
rd_addr  in  5  destination register (0 = none)
rd_wdata  in  32  destination write data
pc  in  32  retired instruction PC
dvalid  in  1  core data-bus request valid
dready  in  1  core data-bus ready
dwrite  in  1  data access is a write
daddr  in  32  data address
dwstb  in  4  write byte strobes
dwdata  in  32  write data
drdata  in  32  read data, valid when dvalid&&dready
out_valid  out  1  record available
out_ready  in  1  sink accepts record
out_pc, out_instr, out_rd_wdata, out_mem_addr, out_mem_data  out  32 each  record fields
out_intr  out  1  record trap flag
out_rd_addr  out  5  record rd
out_mem_rmask, out_mem_wmask  out  4 each  access masks
ovf_clr  in  1  clear overflow flag and drop counter
overflow  out  1  sticky: at least one record dropped
drop_count  out  DROP_CNT_WIDTH  saturating count of dropped records

Behaviour:
- Clocking and reset: single clock, all state updates on posedge clock. Reset is synchronous, active-high.
- On reset:
  - FIFO emptied; out_valid=0.
  - All out_* data = 0.
  - Capture register cleared.
  - overflow=0, drop_count=0.
- Access capture register (addr, data, rmask, wmask) updates when dvalid&&dready:
  - Write: wmask=dwstb, data=dwdata, rmask=0.
  - Read: rmask=4'hF, data=drdata, wmask=0.
  - addr=daddr in both cases.
  - Several accesses before one retire: last one wins.
- Record push:
  - A push occurs in any cycle with valid||trap.
  - Record = pc, instr, trap, rd_addr, rd_wdata, plus access fields.
  - If dvalid&&dready in the same cycle, the current access bypasses into the record.
  - Otherwise the record uses the capture register contents.
  - Capture register clears to 0 in every push cycle, including the bypass case.
  - Trap with valid=0: record still pushed, with instr/rd fields taken as presented.
- FIFO and output:
  - First-word-fall-through. Push in cycle N gives out_valid=1 in cycle N+1 if the FIFO was empty.
  - Pop when out_valid&&out_ready. Out fields are stable while out_valid=1 and out_ready=0.
  - Out fields hold their last value when empty; only out_valid is deasserted.
- Full conditions:
  - Full with pop in the same cycle: push accepted, occupancy unchanged.
  - Full with no pop: record dropped, overflow set, drop_count increments.
  - drop_count saturates at all-ones, no wrap.
- Empty with push and out_ready=1 in the same cycle: no pop, since out_valid is still 0. The record appears next cycle.
- ovf_clr:
  - Clears overflow and drop_count next cycle.
  - If a drop occurs in the same cycle as ovf_clr, the drop wins: overflow=1, drop_count=1.
- Pointers: wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Reset mid-operation: pending records and a partially captured access are discarded; nothing is emitted after reset.

Optional Feature:
Macro RV_TRACE_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 32-bit cycle counter, reset to 0 and wrapping at 2^32.
  - Adds output port out_timestamp (32). Each record stores the counter value of its push cycle.
  - Record width grows by 32.
- Undefined: no counter, no port, and record contents are otherwise unchanged.

Test Plan:
- Reset, then valid=1 with pc=0x100, instr=0x00000013, rd=0, no access → out_valid=1 next cycle with those values, all masks 0; pop with out_ready=1 → out_valid=0.
- Store: dvalid&&dready, dwrite=1, daddr=0x2000, dwstb=4'b0011, dwdata=0xCAFE; retire 2 cycles later → out_mem_addr=0x2000, wmask=3, rmask=0, data=0xCAFE. The following record has all mem fields 0.
- Load with dvalid&&dready in the same cycle as valid, drdata=0x12345678 → record rmask=4'hF, data=0x12345678 (bypass). The next record has no access.
- out_ready=0, 10 consecutive retires with FIFO_DEPTH=8 → 8 records held, overflow=1, drop_count=2. The drained order matches push order; pulsing ovf_clr → overflow=0, drop_count=0.
- FIFO full, out_ready=1 and valid=1 in the same cycle → no drop, occupancy stays 8. Record out_* fields stay stable while out_ready is held low.
- Assert reset with 3 records queued and a capture pending → out_valid=0 next cycle. The first retire after reset has mem fields 0. With RV_TRACE_TIMESTAMP_EN, the first retire at cycle 5 after reset gives out_timestamp=5.
